codec_config_sequencer: RTL and testbench

Parametrised successor to the fixed nine-command WM8731 init sequencer. Walks a configurable command table and drives an external three-byte I2C_Controller via GO/END/ACK. Retries NACKed writes, reports completion/failure, and supports re-run on demand. Sits between the board control logic (volume switches, reset) and the I2C master in the audio path, clocked by the ~10 kHz I2C control clock.

---
 rtl/codec_config_sequencer_pkg.sv | 59 +++++
 rtl/codec_cmd_rom.sv | 22 ++
 rtl/codec_config_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_codec_config_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_config_sequencer_pkg.sv
// Shared types and constants for the codec configuration sequencer:
// FSM state encoding, WM8731 register addresses and the default
// 16-entry {reg_addr, reg_data} command table.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } seq_state_e;

    // One table entry as it is placed in the low 16 bits of the I2C frame.
    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } cmd_word_t;

    // WM8731 register addresses
    localparam logic [6:0] REG_LVOL   = 7'h02;
    localparam logic [6:0] REG_RVOL   = 7'h03;
    localparam logic [6:0] REG_APATH  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_IFACE  = 7'h07;
    localparam logic [6:0] REG_SAMPLE = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    localparam int TABLE_DEPTH = 16;

    // Builds a table entry from register address and 9-bit payload.
    function automatic cmd_word_t make_cmd(input logic [6:0] addr, input logic [8:0] data);
        cmd_word_t w;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Default power-up sequence. Entries 3 and 4 hold a nominal volume
    // value; the sequencer substitutes the live headphone volume for them.
    localparam cmd_word_t CMD_TABLE [TABLE_DEPTH] = '{
        {REG_RESET,  9'h000},
        {REG_PWR,    9'h000},
        {REG_SAMPLE, 9'h000},
        {REG_LVOL,   9'h079},
        {REG_RVOL,   9'h079},
        {REG_IFACE,  9'h042},
        {REG_APATH,  9'h012},
        {REG_DPATH,  9'h000},
        {REG_ACTIVE, 9'h001},
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/codec_cmd_rom.sv
// Combinational command-table lookup: index -> {reg_addr, reg_data}.
// Indices at or beyond NUM_CMDS return an all-zero word.
module codec_cmd_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_CMDS = 9
) (
    input  logic [3:0] index_i,
    output cmd_word_t  word_o
);

    // Table read with out-of-range entries forced to zero
    always_comb begin
        word_o = 16'h0000;
        if (int'(index_i) < NUM_CMDS) begin
            word_o = CMD_TABLE[index_i];
        end else begin
            word_o = 16'h0000;
        end
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer: walks the command table and drives a
// three-byte I2C controller over GO/END/ACK, retrying NACKed writes.
// Optional build macro VOLUME_TRACK_EN: while in DONE, a change of the
// volume input re-writes only the left/right volume registers.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_CMDS  = 9,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         LVOL_IDX  = 3,
    parameter int         RVOL_IDX  = 4,
    parameter int         MAX_RETRY = 3
) (
    input  logic        clk_i2c,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  volume,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    input  logic        i2c_end,
    input  logic [2:0]  i2c_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  cmd_index,
    output logic [2:0]  retry_cnt
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_CMDS - 1);
    localparam logic [3:0] LVOL_IDX4 = 4'(LVOL_IDX);
    localparam logic [3:0] RVOL_IDX4 = 4'(RVOL_IDX);
    localparam logic [2:0] MAX_RTY3  = 3'(MAX_RETRY);

    seq_state_e  state_q, state_d;
    logic [3:0]  cmd_index_q, cmd_index_d;
    logic [2:0]  retry_q, retry_d;
    logic [2:0]  ack_q, ack_d;
    logic [6:0]  vol_q, vol_d;
    logic        track_q, track_d;
    logic        go_q, go_d;
    logic [23:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    cmd_word_t   rom_word_s;
    logic [8:0]  payload_s;

    codec_cmd_rom #(
        .NUM_CMDS (NUM_CMDS)
    ) u_rom (
        .index_i (cmd_index_q),
        .word_o  (rom_word_s)
    );

    // Volume entries carry the latched volume code instead of table data
    always_comb begin
        payload_s = rom_word_s.data;
        if ((cmd_index_q == LVOL_IDX4) || (cmd_index_q == RVOL_IDX4)) begin
            payload_s = {2'b11, vol_q};
        end else begin
            payload_s = rom_word_s.data;
        end
    end

    // State and datapath registers; reset drops GO immediately
    always_ff @(posedge clk_i2c or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_index_q <= 4'd0;
            retry_q     <= 3'd0;
            ack_q       <= 3'd0;
            vol_q       <= 7'd0;
            track_q     <= 1'b0;
            go_q        <= 1'b0;
            data_q      <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_index_q <= cmd_index_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            vol_q       <= vol_d;
            track_q     <= track_d;
            go_q        <= go_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state, command index, retry and volume bookkeeping
    always_comb begin
        state_d     = state_q;
        cmd_index_d = cmd_index_q;
        retry_d     = retry_q;
        ack_d       = ack_q;
        vol_d       = vol_q;
        track_d     = track_q;
        case (state_q)
            ST_IDLE: begin
                state_d     = ST_SEND;
                cmd_index_d = 4'd0;
                retry_d     = 3'd0;
                track_d     = 1'b0;
                vol_d       = volume;
            end
            ST_SEND: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // END still high here belongs to the previous transfer
                if (!i2c_end) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (i2c_end) begin
                    state_d = ST_CHECK;
                    ack_d   = i2c_ack;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_CHECK: begin
                if (ack_q == 3'b000) begin
                    retry_d = 3'd0;
                    if (track_q) begin
                        // Volume-only update: left then right, then idle again
                        if (cmd_index_q == LVOL_IDX4) begin
                            cmd_index_d = RVOL_IDX4;
                            state_d     = ST_SEND;
                        end else begin
                            track_d = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else if (cmd_index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        cmd_index_d = cmd_index_q + 4'd1;
                        state_d     = ST_SEND;
                    end
                end else if (retry_q < MAX_RTY3) begin
                    retry_d = retry_q + 3'd1;
                    state_d = ST_SEND;
                end else begin
                    track_d = 1'b0;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d     = ST_SEND;
                    cmd_index_d = 4'd0;
                    retry_d     = 3'd0;
                    track_d     = 1'b0;
                    vol_d       = volume;
`ifdef VOLUME_TRACK_EN
                end else if (volume != vol_q) begin
                    state_d     = ST_SEND;
                    cmd_index_d = LVOL_IDX4;
                    retry_d     = 3'd0;
                    track_d     = 1'b1;
                    vol_d       = volume;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_d     = ST_SEND;
                    cmd_index_d = 4'd0;
                    retry_d     = 3'd0;
                    track_d     = 1'b0;
                    vol_d       = volume;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values: frame and GO on SEND, GO release on END, status flags
    always_comb begin
        go_d   = go_q;
        data_d = data_q;
        case (state_q)
            ST_SEND: begin
                data_d = {DEV_ADDR, 1'b0, rom_word_s.addr, payload_s};
                go_d   = 1'b1;
            end
            ST_WAIT_HI: begin
                if (i2c_end) begin
                    go_d = 1'b0;
                end else begin
                    go_d = 1'b1;
                end
            end
            default: begin
                go_d   = go_q;
                data_d = data_q;
            end
        endcase
        busy_d  = !((state_d == ST_DONE) || (state_d == ST_ERR));
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    assign i2c_go    = go_q;
    assign i2c_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cmd_index = cmd_index_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed testbench for codec_config_sequencer with a behavioural
// I2C controller responder that logs every frame it is asked to send.
module tb_codec_config_sequencer;

    logic        clk_i2c;
    logic        reset;
    logic        start;
    logic [6:0]  volume;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic [2:0]  i2c_ack;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  cmd_index;
    logic [2:0]  retry_cnt;

    int          total_checks;
    int          passed_checks;

    // Responder model state
    logic [23:0] log_q[$];
    int          xfer_cnt;
    int          max_retry_seen;
    logic [6:0]  nack_addr;
    int          nack_left;
    int          resp_phase;
    int          resp_wait;

    codec_config_sequencer dut (
        .clk_i2c   (clk_i2c),
        .reset     (reset),
        .start     (start),
        .volume    (volume),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .i2c_end   (i2c_end),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_index (cmd_index),
        .retry_cnt (retry_cnt)
    );

    initial clk_i2c = 1'b0;
    always #5 clk_i2c = ~clk_i2c;

    // Controller model: END low on accepted GO, high with ACK a few cycles later
    always @(negedge clk_i2c) begin
        if (reset) begin
            i2c_end    = 1'b1;
            i2c_ack    = 3'b000;
            resp_phase = 0;
            resp_wait  = 0;
        end else begin
            case (resp_phase)
                0: begin
                    if (i2c_go) begin
                        log_q.push_back(i2c_data);
                        xfer_cnt = xfer_cnt + 1;
                        if (int'(retry_cnt) > max_retry_seen) max_retry_seen = int'(retry_cnt);
                        i2c_end    = 1'b0;
                        resp_wait  = 2;
                        resp_phase = 1;
                    end
                end
                1: begin
                    if (resp_wait > 0) begin
                        resp_wait = resp_wait - 1;
                    end else begin
                        if ((log_q[log_q.size()-1][15:9] == nack_addr) && (nack_left > 0)) begin
                            i2c_ack   = 3'b010;
                            nack_left = nack_left - 1;
                        end else begin
                            i2c_ack = 3'b000;
                        end
                        i2c_end    = 1'b1;
                        resp_phase = 2;
                    end
                end
                default: begin
                    if (!i2c_go) resp_phase = 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks = total_checks + 1;
        assert (obs === exp) passed_checks = passed_checks + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        log_q.delete();
        xfer_cnt       = 0;
        max_retry_seen = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk_i2c);
        start = 1'b1;
        @(negedge clk_i2c);
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int n;
        n = 0;
        while (!(done || error) && (n < budget)) begin
            @(posedge clk_i2c);
            #1;
            n = n + 1;
        end
        check("finish_timeout", {31'd0, (done || error)}, 32'd1);
    endtask

    function automatic int count_addr(input logic [6:0] addr);
        int c;
        c = 0;
        foreach (log_q[i]) if (log_q[i][15:9] == addr) c = c + 1;
        return c;
    endfunction

    function automatic logic [23:0] log_at(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        else return 24'hDEAD00;
    endfunction

    initial begin
        bit found;
        total_checks  = 0;
        passed_checks = 0;
        nack_addr     = 7'h7F;
        nack_left     = 0;
        xfer_cnt      = 0;
        max_retry_seen = 0;
        reset  = 1'b1;
        start  = 1'b0;
        volume = 7'h79;
        i2c_end = 1'b1;
        i2c_ack = 3'b000;

        // Reset state
        repeat (3) @(negedge clk_i2c);
        check("rst_go",    {31'd0, i2c_go},  32'd0);
        check("rst_data",  {8'd0, i2c_data}, 32'd0);
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_done",  {31'd0, done},    32'd0);
        check("rst_error", {31'd0, error},   32'd0);
        check("rst_idx",   {28'd0, cmd_index}, 32'd0);
        check("rst_retry", {29'd0, retry_cnt}, 32'd0);

        // Release: GO rises on the second edge with command 0
        clear_log();
        @(negedge clk_i2c);
        reset = 1'b0;
        @(posedge clk_i2c); #1;
        check("rel_edge1_go", {31'd0, i2c_go}, 32'd0);
        check("rel_edge1_busy", {31'd0, busy}, 32'd1);
        @(posedge clk_i2c); #1;
        check("rel_edge2_go", {31'd0, i2c_go}, 32'd1);
        check("rel_edge2_data", {8'd0, i2c_data}, 32'h00341E00);

        // END handshake timing on the first transfer
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_i2c); #1;
            if (!i2c_end) found = 1'b1;
        end
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_i2c); #1;
            if (i2c_end) found = 1'b1;
        end
        check("end_seen", {31'd0, found}, 32'd1);
        check("go_held_at_end", {31'd0, i2c_go}, 32'd1);
        @(posedge clk_i2c); #1;
        check("go_drop_1edge", {31'd0, i2c_go}, 32'd0);
        @(posedge clk_i2c); #1;
        check("go_low_2edge", {31'd0, i2c_go}, 32'd0);
        @(posedge clk_i2c); #1;
        check("go_high_3edge", {31'd0, i2c_go}, 32'd1);
        check("cmd1_data", {8'd0, i2c_data}, 32'h00340C00);

        // Full ACK-always sequence
        wait_finish(600);
        check("run1_xfers", xfer_cnt, 32'd9);
        check("run1_done",  {31'd0, done},  32'd1);
        check("run1_error", {31'd0, error}, 32'd0);
        check("run1_busy",  {31'd0, busy},  32'd0);
        check("run1_idx",   {28'd0, cmd_index}, 32'd8);
        check("run1_d0", {8'd0, log_at(0)}, 32'h00341E00);
        check("run1_d3", {8'd0, log_at(3)}, 32'h003405F9);
        check("run1_d4", {8'd0, log_at(4)}, 32'h003407F9);
        check("run1_d8", {8'd0, log_at(8)}, 32'h00341201);

        // Two NACKs on command 2, plus a start pulse while busy
        clear_log();
        nack_addr = 7'h08;
        nack_left = 2;
        pulse_start();
        repeat (20) @(posedge clk_i2c);
        #1;
        check("busy_mid_run", {31'd0, busy}, 32'd1);
        pulse_start();
        wait_finish(800);
        check("nack2_xfers", xfer_cnt, 32'd11);
        check("nack2_cmd2_sends", count_addr(7'h08), 32'd3);
        check("nack2_retry_peak", max_retry_seen, 32'd2);
        check("nack2_done", {31'd0, done}, 32'd1);
        check("nack2_retry_end", {29'd0, retry_cnt}, 32'd0);

        // Permanent NACK on command 5 exhausts retries
        clear_log();
        nack_addr = 7'h07;
        nack_left = 1000;
        pulse_start();
        wait_finish(800);
        check("err_flag",  {31'd0, error}, 32'd1);
        check("err_done",  {31'd0, done},  32'd0);
        check("err_busy",  {31'd0, busy},  32'd0);
        check("err_idx",   {28'd0, cmd_index}, 32'd5);
        check("err_retry", {29'd0, retry_cnt}, 32'd3);
        check("err_attempts", count_addr(7'h07), 32'd4);
        check("err_xfers", xfer_cnt, 32'd9);

        // Restart from ERR
        clear_log();
        nack_left = 0;
        pulse_start();
        wait_finish(600);
        check("rerun_d0", {8'd0, log_at(0)}, 32'h00341E00);
        check("rerun_done", {31'd0, done}, 32'd1);
        check("rerun_xfers", xfer_cnt, 32'd9);

        // Volume change while in DONE
        clear_log();
        @(negedge clk_i2c);
        volume = 7'h60;
        repeat (80) @(posedge clk_i2c);
        #1;
`ifdef VOLUME_TRACK_EN
        check("vtrack_xfers", xfer_cnt, 32'd2);
        check("vtrack_l", {8'd0, log_at(0)}, 32'h003405E0);
        check("vtrack_r", {8'd0, log_at(1)}, 32'h003407E0);
`else
        check("vtrack_xfers", xfer_cnt, 32'd0);
`endif
        check("vtrack_done", {31'd0, done}, 32'd1);

        // Reset while GO is high on command 4
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk_i2c);
            if (i2c_go && (cmd_index == 4'd4)) found = 1'b1;
        end
        check("mid_cmd4_seen", {31'd0, found}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_go", {31'd0, i2c_go}, 32'd0);
        check("mid_rst_idx", {28'd0, cmd_index}, 32'd0);
        repeat (2) @(negedge clk_i2c);
        clear_log();
        reset = 1'b0;
        wait_finish(600);
        check("mid_d0", {8'd0, log_at(0)}, 32'h00341E00);
        check("mid_d3", {8'd0, log_at(3)}, 32'h003405E0);
        check("mid_xfers", xfer_cnt, 32'd9);
        check("mid_done", {31'd0, done}, 32'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
